// File: rtl/fpga_cfg_pkg.sv
// Shared constants for the configuration-chain loader.
// Holds the FSM state encoding and the default chain/word geometry.
package fpga_cfg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int DEFAULT_CHAIN_LEN = 64;
    localparam int DEFAULT_DATA_W    = 8;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in/serial-out word register feeding the config chain, LSB first.
// A load takes priority over a shift in the same cycle.
module cfg_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              sdo_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sdo_o = shreg_q[0];

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial configuration loader: takes bitstream words over valid/ready, shifts
// exactly CHAIN_LEN bits into the config DFF chain, then strobes the latch.
module cfg_chain_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              cfg_sdo_o,
    output logic              cfg_shift_en_o,
    output logic              cfg_latch_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(DATA_W - 1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [WB_W-1:0]  word_bits_q, word_bits_d;
    logic             done_q,      done_d;
    logic             word_load;
    logic             shifting;
    logic             piso_sdo;

    assign word_load = (state_q == ST_WAIT) && in_valid_i;
    assign shifting  = (state_q == ST_SHIFT);

    // Chain end has priority over word end, so surplus high bits of the final word are dropped.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_bits_d = word_bits_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_WAIT;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                if (in_valid_i) begin
                    state_d     = ST_SHIFT;
                    word_bits_d = '0;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d   = bit_cnt_q + 1'b1;
                word_bits_d = word_bits_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_LATCH;
                end else if (word_bits_q == LAST_WBIT) begin
                    state_d = ST_WAIT;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE, and never sets or clears done.
        if (abort_i) begin
            state_d = ST_IDLE;
            done_d  = done_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_bits_q <= word_bits_d;
            done_q      <= done_d;
        end
    end

    cfg_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (word_load),
        .shift_i (shifting),
        .data_i  (in_data_i),
        .sdo_o   (piso_sdo)
    );

    assign in_ready_o     = (state_q == ST_WAIT);
    assign cfg_shift_en_o = shifting;
    assign cfg_sdo_o      = shifting & piso_sdo;
    assign cfg_latch_o    = (state_q == ST_LATCH);
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;

endmodule
